// File: rtl/enigma_rotor_stage.sv
`default_nettype none
// ============================================================================
//  Module      : enigma_rotor_stage
//  Description : Pipelined Enigma rotor stage. Holds a rotor position and
//                applies position-offset wiring substitution to a stream of
//                letter indices over a valid/ready handshake, with a single
//                registered output stage. Produces a one-cycle notch carry
//                for chaining stages into an odometer-stepping rotor bank.
//                Optional macro ENIGMA_ROTOR_REVERSE_EN adds the dir_rev
//                input and the inverse-wiring return path.
//  Revision    : 1.0 - initial release
// ============================================================================
module enigma_rotor_stage #(
    parameter int ALPHA = 26,
    parameter int W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ALPHA*W-1:0]   wiring,
    input  logic [W-1:0]         notch,
    input  logic                 load_en,
    input  logic [W-1:0]         load_pos,
    input  logic                 step_in,
    input  logic                 in_valid,
    input  logic [W-1:0]         in_idx,
`ifdef ENIGMA_ROTOR_REVERSE_EN
    input  logic                 dir_rev,
`endif
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         out_idx,
    output logic                 out_err,
    output logic [W-1:0]         pos,
    output logic                 carry_out
);

    // ALPHA in the widened (W+1) domain for sums, and in the W domain for
    // wrap-around corrections whose true result is known to fit in W bits.
    localparam logic [W:0]   c_ALPHA_X = (W+1)'(ALPHA);
    localparam logic [W-1:0] c_ALPHA_W = W'(ALPHA);
    localparam logic [W-1:0] c_LAST    = W'(ALPHA - 1);

    logic [W-1:0] r_pos;
    logic         r_out_valid;
    logic [W-1:0] r_out_idx;
    logic         r_out_err;
    logic         r_carry;

    logic [W-1:0] w_tab [ALPHA];
    logic [W:0]   w_sum;
    logic [W:0]   w_e;
    logic [W-1:0] w_sel;
    logic         w_in_bad;
    logic         w_fwd_bad;
    logic [W-1:0] w_fwd_idx;
    logic         w_res_err;
    logic [W-1:0] w_res_idx;
    logic         w_accept;
    logic [W-1:0] w_load_mod;

    // Unpack the wiring bus; entry 0 sits at the MSBs.
    generate
        for (genvar gk = 0; gk < ALPHA; gk++) begin : g_tab
            assign w_tab[gk] = wiring[(ALPHA-gk)*W-1 -: W];
        end
    endgenerate

    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    // Forward path: offset entry point, table lookup, remove the offset again.
    always_comb begin
        w_sum    = {1'b0, in_idx} + {1'b0, r_pos};
        w_e      = (w_sum >= c_ALPHA_X) ? (w_sum - c_ALPHA_X) : w_sum;
        w_in_bad = ({1'b0, in_idx} >= c_ALPHA_X);
        // Mux over legal entries only, so an out-of-range e never indexes past the table.
        w_sel = '0;
        for (int k = 0; k < ALPHA; k++) begin
            if (w_e == (W+1)'(k)) begin
                w_sel = w_tab[k];
            end
        end
        w_fwd_bad = ({1'b0, w_sel} >= c_ALPHA_X);
        // The result is < ALPHA, so W-bit wrap-around arithmetic is exact here.
        w_fwd_idx = (w_sel >= r_pos) ? (w_sel - r_pos) : (w_sel - r_pos + c_ALPHA_W);
    end

`ifdef ENIGMA_ROTOR_REVERSE_EN
    logic         w_rev_hit;
    logic [W-1:0] w_rev_k;
    logic [W-1:0] w_rev_idx;

    // Return path: priority-encode the lowest entry whose value equals j.
    always_comb begin
        w_rev_hit = 1'b0;
        w_rev_k   = '0;
        for (int k = ALPHA - 1; k >= 0; k--) begin
            if ({1'b0, w_tab[k]} == w_e) begin
                w_rev_hit = 1'b1;
                w_rev_k   = W'(k);
            end
        end
        w_rev_idx = (w_rev_k >= r_pos) ? (w_rev_k - r_pos) : (w_rev_k - r_pos + c_ALPHA_W);
    end

    // Select direction and fold in the error conditions.
    always_comb begin
        if (dir_rev) begin
            w_res_err = w_in_bad || !w_rev_hit;
            w_res_idx = w_rev_idx;
        end else begin
            w_res_err = w_in_bad || w_fwd_bad;
            w_res_idx = w_fwd_idx;
        end
        if (w_res_err) begin
            w_res_idx = '0;
        end
    end
`else
    // Fold in the error conditions; an erroring result reports index 0.
    always_comb begin
        w_res_err = w_in_bad || w_fwd_bad;
        w_res_idx = w_res_err ? '0 : w_fwd_idx;
    end
`endif

    // Reduce a loaded position that is at most one alphabet length too large.
    always_comb begin
        w_load_mod = ({1'b0, load_pos} >= c_ALPHA_X) ? (load_pos - c_ALPHA_W) : load_pos;
    end

    // Output register: capture on accept, drop valid on transfer, hold while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
            r_out_err   <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_idx   <= w_res_idx;
            r_out_err   <= w_res_err;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Rotor position and notch carry; load has priority over step.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pos   <= '0;
            r_carry <= 1'b0;
        end else if (load_en) begin
            r_pos   <= w_load_mod;
            r_carry <= 1'b0;
        end else if (step_in) begin
            r_pos   <= (r_pos == c_LAST) ? '0 : (r_pos + 1'b1);
            r_carry <= (r_pos == notch);
        end else begin
            r_carry <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_idx   = r_out_idx;
    assign out_err   = r_out_err;
    assign pos       = r_pos;
    assign carry_out = r_carry;

endmodule
`default_nettype wire
